if_fetch_unit: RTL and testbench

- Instruction-fetch stage that produces PC+4, the instruction word and the 2-bit hazard control code for the IF/ID pipeline register.
- Owns the PC, talks to instruction memory through a req/gnt/rvalid handshake, buffers one returned instruction and accepts redirects from ID/EX.
- Emits a bubble (flush code) whenever no valid instruction is ready, so IF/ID never captures garbage.

---
 rtl/if_fetch_unit.sv | 202 ++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/gnt/rvalid handshake,
// buffers one instruction for IF/ID. Optional perf counters: IF_FETCH_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] fetch_pc4_o,
    output logic [31:0] fetch_inst_o,
    output logic        fetch_valid_o,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_bubble_cnt_o,
`endif
    output logic [1:0]  hz_ctrl_o
);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [1:0] HZ_LOAD  = 2'b00;
    localparam logic [1:0] HZ_FLUSH = 2'b01;
    localparam logic [1:0] HZ_STALL = 2'b10;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] inst_r, inst_s;
    logic [31:0] pc4_r, pc4_s;
    logic        valid_r, valid_s;

    logic [1:0]  hz_ctrl_s;
    logic        consume_s;
    logic        room_s;
    logic        req_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] redirect_tgt_s;

    // Hazard code and request qualification for the current cycle
    always_comb begin
        hz_ctrl_s = HZ_FLUSH;
        if (redirect_i) begin
            hz_ctrl_s = HZ_FLUSH;
        end else if (stall_i) begin
            hz_ctrl_s = HZ_STALL;
        end else if (valid_r) begin
            hz_ctrl_s = HZ_LOAD;
        end else begin
            hz_ctrl_s = HZ_FLUSH;
        end
        consume_s      = (hz_ctrl_s == HZ_LOAD);
        room_s         = !valid_r || consume_s;
        req_s          = (state_r == ST_REQ) && room_s && !rst;
        pc_plus4_s     = pc_r + 32'd4;
        redirect_tgt_s = redirect_pc_i & ~32'd3;
    end

    // Next-state logic for PC, buffer and fetch FSM
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        inst_s  = inst_r;
        pc4_s   = pc4_r;
        valid_s = valid_r;

        if (consume_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end

        case (state_r)
            ST_REQ: begin
                if (req_s && imem_gnt_i) begin
                    pc_s = pc_plus4_s;
                    if (imem_rvalid_i) begin
                        inst_s  = imem_rdata_i;
                        pc4_s   = pc_plus4_s;
                        valid_s = 1'b1;
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                // pc_r already points past this instruction
                if (imem_rvalid_i) begin
                    inst_s  = imem_rdata_i;
                    pc4_s   = pc_r;
                    valid_s = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DISCARD: begin
                if (imem_rvalid_i) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: begin
                state_s = ST_REQ;
            end
        endcase

        // A redirect overrides everything computed above
        if (redirect_i) begin
            pc_s    = redirect_tgt_s;
            inst_s  = inst_r;
            pc4_s   = pc4_r;
            valid_s = 1'b0;
            case (state_r)
                ST_REQ: begin
                    if (req_s && imem_gnt_i && !imem_rvalid_i) begin
                        state_s = ST_DISCARD;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_WAIT, ST_DISCARD: begin
                    if (imem_rvalid_i) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end
                default: begin
                    state_s = ST_REQ;
                end
            endcase
        end else begin
            pc_s = pc_s;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_REQ;
            pc_r    <= RESET_PC;
            inst_r  <= 32'd0;
            pc4_r   <= 32'd0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            inst_r  <= inst_s;
            pc4_r   <= pc4_s;
            valid_r <= valid_s;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_bubble_r;

    // Saturating fetch and bubble counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_r  <= 32'd0;
            perf_bubble_r <= 32'd0;
        end else begin
            if (consume_s && (perf_fetch_r != 32'hFFFFFFFF)) begin
                perf_fetch_r <= perf_fetch_r + 32'd1;
            end else begin
                perf_fetch_r <= perf_fetch_r;
            end
            if ((hz_ctrl_s == HZ_FLUSH) && !redirect_i && (perf_bubble_r != 32'hFFFFFFFF)) begin
                perf_bubble_r <= perf_bubble_r + 32'd1;
            end else begin
                perf_bubble_r <= perf_bubble_r;
            end
        end
    end

    assign perf_fetch_cnt_o  = perf_fetch_r;
    assign perf_bubble_cnt_o = perf_bubble_r;
`endif

    assign imem_req_o    = req_s;
    assign imem_addr_o   = {pc_r[31:2], 2'b00};
    assign hz_ctrl_o     = hz_ctrl_s;
    assign fetch_pc4_o   = pc4_r;
    assign fetch_inst_o  = inst_r;
    assign fetch_valid_o = valid_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit: zero-wait and latent memory,
// stall, redirects in WAIT and REQ, PC wrap and reset during WAIT.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] fetch_pc4_o;
    logic [31:0] fetch_inst_o;
    logic        fetch_valid_o;
    logic [1:0]  hz_ctrl_o;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_bubble_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(.RESET_PC(32'h00000000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .fetch_pc4_o   (fetch_pc4_o),
        .fetch_inst_o  (fetch_inst_o),
        .fetch_valid_o (fetch_valid_o),
`ifdef IF_FETCH_PERF_CNT_EN
        .perf_fetch_cnt_o  (perf_fetch_cnt_o),
        .perf_bubble_cnt_o (perf_bubble_cnt_o),
`endif
        .hz_ctrl_o     (hz_ctrl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let combinational outputs settle
    task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic g, input logic rv, input logic [31:0] rdat);
        @(negedge clk);
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_gnt_i    = g;
        imem_rvalid_i = rv;
        imem_rdata_i  = rdat;
        #1;
    endtask

    task automatic chk_buf(input string tag, input logic v, input logic [31:0] pc4, input logic [31:0] inst);
        chk({tag, "_valid"}, {31'd0, fetch_valid_o}, {31'd0, v});
        chk({tag, "_pc4"}, fetch_pc4_o, pc4);
        chk({tag, "_inst"}, fetch_inst_o, inst);
    endtask

    task automatic chk_io(input string tag, input logic req, input logic [31:0] addr, input logic [1:0] hz);
        chk({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, req});
        chk({tag, "_addr"}, imem_addr_o, addr);
        chk({tag, "_hz"}, {30'd0, hz_ctrl_o}, {30'd0, hz});
    endtask

    initial begin
        rst = 1'b0;
        stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
        #2 rst = 1'b1;
        #1;
        chk_io("rst", 1'b0, 32'h0, 2'b01);
        chk_buf("rst", 1'b0, 32'h0, 32'h0);

        // Zero-wait memory
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20080005);
        chk_io("zw0", 1'b1, 32'h0, 2'b01);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA0001);
        chk_io("zw1", 1'b1, 32'h4, 2'b00);
        chk_buf("zw1", 1'b1, 32'h4, 32'h20080005);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hBBBB0002);
        chk_io("zw2", 1'b1, 32'h8, 2'b00);
        chk_buf("zw2", 1'b1, 32'h8, 32'hAAAA0001);

        // Two-cycle latency: request at 0xC, data two cycles later
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_io("lat0", 1'b1, 32'hC, 2'b00);
        chk_buf("lat0", 1'b1, 32'hC, 32'hBBBB0002);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_io("lat1", 1'b0, 32'h10, 2'b01);
        chk_buf("lat1", 1'b0, 32'hC, 32'hBBBB0002);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCCCC0003);
        chk_io("lat2", 1'b0, 32'h10, 2'b01);

        // Stall for three cycles while holding a valid instruction
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk_io("stall", 1'b0, 32'h10, 2'b10);
            chk_buf("stall", 1'b1, 32'h10, 32'hCCCC0003);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_io("resume", 1'b1, 32'h10, 2'b00);
        chk_buf("resume", 1'b1, 32'h10, 32'hCCCC0003);

        // Redirect while in WAIT; the late data must be dropped
        cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        chk_io("rdw0", 1'b0, 32'h14, 2'b01);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        chk_io("rdw1", 1'b0, 32'h100, 2'b01);
        chk_buf("rdw1", 1'b0, 32'h10, 32'hCCCC0003);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h11110000);
        chk_io("rdw2", 1'b1, 32'h100, 2'b01);
        chk_buf("rdw2", 1'b0, 32'h10, 32'hCCCC0003);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_io("rdw3", 1'b1, 32'h104, 2'b00);
        chk_buf("rdw3", 1'b1, 32'h104, 32'h11110000);

        // Redirect together with a grant in REQ: misaligned target, DISCARD entered
        cyc(1'b0, 1'b1, 32'h203, 1'b1, 1'b0, 32'h0);
        chk_io("rdq0", 1'b1, 32'h104, 2'b01);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0BAD0);
        chk_io("rdq1", 1'b0, 32'h200, 2'b01);
        chk_buf("rdq1", 1'b0, 32'h104, 32'h11110000);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_io("rdq2", 1'b1, 32'h200, 2'b01);
        chk_buf("rdq2", 1'b0, 32'h104, 32'h11110000);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h22220000);
        chk_io("rdq3", 1'b0, 32'h204, 2'b01);

        // Redirect and stall together: redirect wins and clears the buffer
        cyc(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        chk_io("rs0", 1'b0, 32'h204, 2'b01);
        chk_buf("rs0", 1'b1, 32'h204, 32'h22220000);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_io("rs1", 1'b1, 32'h300, 2'b01);
        chk({"rs1", "_valid"}, {31'd0, fetch_valid_o}, 32'd0);

        // PC+4 wraps past the top of the address space
        cyc(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h33330000);
        chk_io("wrap0", 1'b1, 32'hFFFFFFFC, 2'b01);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_io("wrap1", 1'b1, 32'h0, 2'b00);
        chk_buf("wrap1", 1'b1, 32'h0, 32'h33330000);

        // Reset asserted while a request is outstanding
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk_io("rw0", 1'b1, 32'h0, 2'b01);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_io("rw1", 1'b0, 32'h4, 2'b01);
        rst = 1'b1;
        #1;
        chk_io("rw_rst", 1'b0, 32'h0, 2'b01);
        chk_buf("rw_rst", 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h44440000);
        chk_io("post0", 1'b1, 32'h0, 2'b01);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk_io("post1", 1'b1, 32'h4, 2'b00);
        chk_buf("post1", 1'b1, 32'h4, 32'h44440000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
